// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared types and widths for the MEM pipeline stage.
//   ex_bus_t  : payload from EX  = {ld_op, req_sent, addr_lo, wb_bus_t}
//   wb_bus_t  : payload to WB    = {rf_we, waddr, wdata, pc, read_tid, csr_re,
//               csr_we, csr_num, wmask, wvalue, ertn, exc_en, exc flags, esubcode}
//   id_bus_t  : forwarding/stall = {rf_we, waddr, wdata, ld_block, csr_block}
//   ld_op_t   : one-hot load kind {b, h, w, bu, hu}
// -----------------------------------------------------------------------------
package mem_stage_pkg;

    localparam int EX_BUS_W = 176;
    localparam int WB_BUS_W = 168;
    localparam int ID_BUS_W = 40;

    typedef struct packed {
        logic b;
        logic h;
        logic w;
        logic bu;
        logic hu;
    } ld_op_t;

    typedef struct packed {
        logic exc_int;
        logic adef;
        logic ale;
        logic sys;
        logic brk;
        logic ine;
    } exc_flags_t;

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic        read_tid;
        logic        csr_re;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] wmask;
        logic [31:0] wvalue;
        logic        ertn;
        logic        exc_en;
        exc_flags_t  exc;
        logic [8:0]  esubcode;
    } wb_bus_t;

    typedef struct packed {
        ld_op_t      ld_op;
        logic        req_sent;
        logic [1:0]  addr_lo;
        wb_bus_t     wb;
    } ex_bus_t;

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        ld_block;
        logic        csr_block;
    } id_bus_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// -----------------------------------------------------------------------------
// mem_load_align
// Combinational load-data alignment and extension.
//   ld_op   in  5   one-hot load kind {b, h, w, bu, hu}
//   addr_lo in  2   low address bits of the load
//   rdata   in  32  raw word from the data SRAM
//   wdata   out 32  aligned, sign/zero-extended register write value
// Misaligned halfword/word loads never reach here (ALE is taken in EX).
// -----------------------------------------------------------------------------
module mem_load_align
    import mem_stage_pkg::*;
(
    input  ld_op_t      ld_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] wdata
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = rdata[{addr_lo, 3'b000} +: 8];
    assign half_v = rdata[{addr_lo[1], 4'b0000} +: 16];

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if-chain can leave it unassigned and infer a latch.
    always_comb begin
        wdata = 32'h0;
        if (ld_op.b)       wdata = {{24{byte_v[7]}}, byte_v};
        else if (ld_op.bu) wdata = {24'h0, byte_v};
        else if (ld_op.h)  wdata = {{16{half_v[15]}}, half_v};
        else if (ld_op.hu) wdata = {16'h0, half_v};
        else if (ld_op.w)  wdata = rdata;
    end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// MEM pipeline stage between EX and WB. Holds the EX result, waits for the
// data-SRAM response of a load issued in EX, aligns the load data and drives
// the WB bus, the ID forwarding/stall bus and the EX store-cancel bit.
// Responses belonging to flushed instructions are dropped via discard_cnt.
//
// Ports
//   clk, resetn         clock, synchronous active-low reset
//   ex_to_mem_valid/bus EX payload (176 bits), mem_allowin back to EX
//   ex_req_pending      EX has an issued request not yet in MEM
//   data_sram_data_ok   response strobe, data_sram_rdata response data
//   wb_allowin          WB ready; mem_to_wb_valid/bus (168 bits) to WB
//   mem_to_id_bus       {rf_we, waddr, wdata, ld_block, csr_block}
//   mem_to_ex_bus       resident exception/ertn: EX must not issue a store
//   wb_ex, ertn_flush   pipeline flush from WB
//
// Configuration macro MEM_RDATA_BUF_EN: when defined, the response is held in
// a one-entry buffer so a data_ok during a WB stall is kept. When undefined,
// the response is used combinationally and WB must be ready on data_ok.
// -----------------------------------------------------------------------------
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                ex_to_mem_valid,
    input  logic [EX_BUS_W-1:0] ex_to_mem_bus,
    output logic                mem_allowin,
    input  logic                ex_req_pending,
    input  logic                data_sram_data_ok,
    input  logic [31:0]         data_sram_rdata,
    input  logic                wb_allowin,
    output logic                mem_to_wb_valid,
    output logic [WB_BUS_W-1:0] mem_to_wb_bus,
    output logic [ID_BUS_W-1:0] mem_to_id_bus,
    output logic                mem_to_ex_bus,
    input  logic                wb_ex,
    input  logic                ertn_flush
);

    logic        mem_valid;
    ex_bus_t     mem_r;
    logic [1:0]  discard_cnt;
    logic [2:0]  discard_sum;
    logic [1:0]  discard_next;

    logic        flush;
    logic        need_data;
    logic        data_ok_for_me;
    logic        got_data;
    logic        ready_go;
    logic        handoff;
    logic        is_load;
    logic        ld_block;
    logic        csr_block;
    logic [31:0] load_rdata;
    logic [31:0] aligned;
    logic [31:0] final_wdata;
    wb_bus_t     wb_out;
    id_bus_t     id_out;

    assign flush          = wb_ex | ertn_flush;
    assign need_data      = mem_valid & mem_r.req_sent & ~mem_r.wb.exc_en;
    assign data_ok_for_me = data_sram_data_ok & (discard_cnt == 2'd0);

`ifdef MEM_RDATA_BUF_EN
    logic        buf_valid;
    logic [31:0] buf_rdata;

    assign got_data   = data_ok_for_me | buf_valid;
    assign load_rdata = buf_valid ? buf_rdata : data_sram_rdata;

    // NOTE: buf_rdata is pure data qualified by buf_valid; only the valid bit
    // needs a reset value.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            buf_valid <= 1'b0;
        end else if (flush || handoff) begin
            buf_valid <= 1'b0;
        end else if (need_data && data_ok_for_me && !buf_valid) begin
            buf_valid <= 1'b1;
            buf_rdata <= data_sram_rdata;
        end
    end
`else
    assign got_data   = data_ok_for_me;
    assign load_rdata = data_sram_rdata;
`endif

    assign ready_go        = ~need_data | got_data;
    assign ld_block        = need_data & ~got_data;
    assign mem_allowin     = ~mem_valid | (ready_go & wb_allowin);
    assign mem_to_wb_valid = mem_valid & ready_go;
    assign handoff         = mem_to_wb_valid & wb_allowin;

    // A flush adds one for the resident load still owed a response and one for
    // the request EX already issued; every response seen while the count is
    // nonzero is dropped. Both effects apply in the same cycle.
    always_comb begin
        discard_sum = {1'b0, discard_cnt};
        if (data_sram_data_ok && discard_cnt != 2'd0)
            discard_sum = discard_sum - 3'd1;
        if (flush)
            discard_sum = discard_sum + {2'b00, ld_block} + {2'b00, ex_req_pending};
        discard_next = (discard_sum > 3'd3) ? 2'd3 : discard_sum[1:0];
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_valid   <= 1'b0;
            discard_cnt <= 2'd0;
        end else begin
            discard_cnt <= discard_next;
            if (flush)
                mem_valid <= 1'b0;
            else if (mem_allowin)
                mem_valid <= ex_to_mem_valid;
        end
    end

    // Payload is reset too, so the WB and ID buses read all-zero out of reset.
    always_ff @(posedge clk) begin
        if (!resetn)
            mem_r <= '0;
        else if (ex_to_mem_valid && mem_allowin)
            mem_r <= ex_to_mem_bus;
    end

    // At most one flushed load plus one in-flight EX request can be owed.
    always_ff @(posedge clk) begin
        if (resetn)
            assert (discard_sum <= 3'd2);
    end

    mem_load_align u_load_align (
        .ld_op   (mem_r.ld_op),
        .addr_lo (mem_r.addr_lo),
        .rdata   (load_rdata),
        .wdata   (aligned)
    );

    assign is_load     = |mem_r.ld_op;
    assign final_wdata = is_load ? aligned : mem_r.wb.wdata;
    assign csr_block   = mem_valid & (mem_r.wb.csr_re | mem_r.wb.read_tid);

    always_comb begin
        wb_out       = mem_r.wb;
        wb_out.wdata = final_wdata;
    end

    always_comb begin
        id_out.rf_we     = mem_valid & mem_r.wb.rf_we;
        id_out.waddr     = mem_r.wb.waddr;
        id_out.wdata     = final_wdata;
        id_out.ld_block  = ld_block;
        id_out.csr_block = csr_block;
    end

    assign mem_to_wb_bus = wb_out;
    assign mem_to_id_bus = id_out;
    assign mem_to_ex_bus = mem_valid & (mem_r.wb.exc_en | mem_r.wb.ertn);

endmodule
